pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It generates the write-enable (WEN) and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC enable. It resolves:
- instruction-fetch misses;
- data-memory waits;
- load-use hazards;
- branch/jump redirects resolved in MEM;
- halt drain.

A small state machine holds multi-cycle memory waits and the terminal halted state, and a saturating counter records stall cycles.

## Interface
- CNT_W, 16, width of stall-cycle counter
- CLK  in  1  system clock, all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low; one clock domain
- ihit  in  1  instruction fetch for current PC completes this cycle
- dhit  in  1  data access by instruction in MEM completes this cycle
- mem_op  in  1  EX/MEM register holds a load or store (MemRead|MemWrite out)
- idex_memread  in  1  ID/EX holds a load
- idex_rt  in  5  destination register of ID/EX load
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- ifid_uses_rt  in  1  IF/ID instruction reads rt
- redirect  in  1  taken branch or jump resolved in MEM this cycle
- halt_wb  in  1  halt instruction present at MEM/WB register output
- pc_WEN  out  1  PC load enable
- ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  clear control bits (bubble)
- halted  out  1  sticky halt indication
- stall_cycles  out  CNT_W  saturating count of cycles with pc_WEN=0 while not halted

## Operation
States: RUN, MEMWAIT, HALTED. Outputs are combinational in state and inputs. Evaluate RUN rules in priority order; the first match wins.

RUN:
1. halt_wb=1: all WEN=0, all flush=0. Next state HALTED.
2. mem_op=1 and dhit=0: all WEN=0, flushes 0. Next state MEMWAIT.
3. redirect=1: pc_WEN=1, all WEN=1, ifid_flush=idex_flush=exmem_flush=1. The wrong-path instructions are squashed; MEM/WB advances normally.
4. Load-use hazard: idex_memread=1, idex_rt≠0, and (idex_rt==ifid_rs or (ifid_uses_rt and idex_rt==ifid_rt)). Outputs: pc_WEN=0, ifid_WEN=0, idex_WEN=1, idex_flush=1, exmem_WEN=memwb_WEN=1. This inserts one bubble. The hazard clears next cycle because the load has moved on.
5. ihit=0: pc_WEN=0, ifid_WEN=1, ifid_flush=1, other WEN=1. A bubble enters IF/ID.
6. Otherwise: pc_WEN and all WEN=1, flushes 0.

MEMWAIT:
- dhit=0: all WEN=0; stay in MEMWAIT.
- dhit=1: apply RUN rules 3–6 this cycle (rule 2 is suppressed); next state RUN.
- halt_wb is ignored in MEMWAIT; it cannot be asserted while MEM is waiting.

HALTED:
- All WEN=0, flushes 0, halted=1.
- Left only by reset.

Other rules:
- Flush takes precedence over WEN inside each register. The controller asserts both when bubbling.
- stall_cycles: increments by 1 on every edge where pc_WEN=0 and state≠HALTED. Saturates at 2^CNT_W−1; it does not wrap.

## Timing
- While nRST=0 at an edge: state←RUN, stall_cycles←0.
- Outputs while reset is held: all WEN=0, all flush=0, halted=0, pc_WEN=0.
- Reset mid-MEMWAIT or in HALTED returns to RUN at that edge.
- First cycle after reset release follows RUN rules.
- Zero-latency control: enables and flushes for cycle N depend only on state and on inputs sampled in cycle N.
- State and counter update at the rising edge ending cycle N.
- A load-use stall costs exactly 1 cycle.
- A data miss costs (cycles until dhit) + 0; the release cycle advances.
- Simultaneous redirect and load-use: redirect wins, and the load-use bubble is not inserted.
- Simultaneous redirect and ihit=0: redirect wins; PC loads the target.
- halted rises the cycle after halt_wb is first seen.

## Test plan
- Reset: hold nRST=0 for 3 cycles with ihit=1 → all WEN=0, halted=0, stall_cycles=0. First release cycle → all WEN=1.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 → one cycle of pc_WEN=0, ifid_WEN=0, idex_flush=1. Next cycle with idex_memread=0 → all WEN=1. stall_cycles=1. Repeat with idex_rt=0 → no stall.
- Data miss: mem_op=1, dhit=0 for 4 cycles, then dhit=1 → 4 cycles of all WEN=0 (state MEMWAIT after the first), all WEN=1 on the dhit cycle, stall_cycles=4.
- Redirect with concurrent hazard: redirect=1 together with a load-use match and ihit=0 → pc_WEN=1; ifid/idex/exmem flush=1; memwb_WEN=1.
- Halt: halt_wb=1 → all WEN=0 that cycle, halted=1 from next cycle. Inputs toggled for 10 cycles → outputs unchanged, stall_cycles frozen. nRST=0 → halted=0.
- Saturation: CNT_W=4, hold ihit=0 for 20 cycles → stall_cycles reaches 15 and stays 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the five-stage pipeline datapath and its hazard controller.
// The pipeline (master) reports hazards; the controller (slave) returns enables and flushes.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             mem_op;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             redirect;
  logic             halt_wb;
  logic             pc_WEN;
  logic             ifid_WEN;
  logic             idex_WEN;
  logic             exmem_WEN;
  logic             memwb_WEN;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ihit, dhit, mem_op, idex_memread, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, redirect, halt_wb,
    input  pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
  );

  modport slave (
    input  ihit, dhit, mem_op, idex_memread, idex_rt, ifid_rs, ifid_rt,
           ifid_uses_rt, redirect, halt_wb,
    output pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: fetch misses, data waits,
// load-use bubbles, MEM-stage redirects and halt drain, plus a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic                    CLK,
  input logic                    nRST,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Packed control word: {pc, ifid, idex, exmem, memwb WEN, ifid, idex, exmem flush}
  localparam logic [7:0] CTL_HOLD     = 8'b00000_000;
  localparam logic [7:0] CTL_ADVANCE  = 8'b11111_000;
  localparam logic [7:0] CTL_REDIRECT = 8'b11111_111;
  localparam logic [7:0] CTL_LOADUSE  = 8'b00111_010;
  localparam logic [7:0] CTL_IMISS    = 8'b01111_100;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_load_use;
  logic [7:0]       w_adv_ctl;
  logic [7:0]       w_ctl;
  logic             w_halted;

  assign w_load_use = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                      ((bus.idex_rt == bus.ifid_rs) ||
                       (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  // Rules shared by RUN and the MEMWAIT release cycle: redirect, load-use, fetch miss.
  always_comb begin
    w_adv_ctl = CTL_ADVANCE;
    if (bus.redirect) begin
      w_adv_ctl = CTL_REDIRECT;
    end else if (w_load_use) begin
      w_adv_ctl = CTL_LOADUSE;
    end else if (!bus.ihit) begin
      w_adv_ctl = CTL_IMISS;
    end
  end

  always_comb begin
    w_ctl        = CTL_HOLD;
    w_halted     = 1'b0;
    w_next_state = r_state;
    if (nRST) begin
      case (r_state)
        ST_RUN: begin
          if (bus.halt_wb) begin
            w_next_state = ST_HALTED;
          end else if (bus.mem_op && !bus.dhit) begin
            w_next_state = ST_MEMWAIT;
          end else begin
            w_ctl = w_adv_ctl;
          end
        end
        ST_MEMWAIT: begin
          if (bus.dhit) begin
            w_ctl        = w_adv_ctl;
            w_next_state = ST_RUN;
          end
        end
        ST_HALTED: begin
          w_halted = 1'b1;
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Halted cycles are drain, not stalls, so they are excluded from the count.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cycles <= '0;
    end else if (!w_ctl[7] && (r_state != ST_HALTED) && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.pc_WEN       = w_ctl[7];
  assign bus.ifid_WEN     = w_ctl[6];
  assign bus.idex_WEN     = w_ctl[5];
  assign bus.exmem_WEN    = w_ctl[4];
  assign bus.memwb_WEN    = w_ctl[3];
  assign bus.ifid_flush   = w_ctl[2];
  assign bus.idex_flush   = w_ctl[1];
  assign bus.exmem_flush  = w_ctl[0];
  assign bus.halted       = w_halted;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a 16-bit-counter instance for the main
// scenarios and a 4-bit-counter instance for counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] CTL_HOLD     = 8'b00000_000;
  localparam logic [7:0] CTL_ADVANCE  = 8'b11111_000;
  localparam logic [7:0] CTL_REDIRECT = 8'b11111_111;
  localparam logic [7:0] CTL_LOADUSE  = 8'b00111_010;
  localparam logic [7:0] CTL_IMISS    = 8'b01111_100;

  logic CLK = 1'b0;
  logic nRST;
  logic nRST4;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  pipeline_hazard_ctrl #(.CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST4), .bus(bus4));

  logic [7:0] ctl;
  assign ctl = {bus.pc_WEN, bus.ifid_WEN, bus.idex_WEN, bus.exmem_WEN, bus.memwb_WEN,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.mem_op = 1'b0; bus.idex_memread = 1'b0;
    bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0; bus.ifid_uses_rt = 1'b0;
    bus.redirect = 1'b0; bus.halt_wb = 1'b0;
  endtask

  initial begin
    nRST  = 1'b0;
    nRST4 = 1'b0;
    idle_inputs();
    bus4.ihit = 1'b0; bus4.dhit = 1'b0; bus4.mem_op = 1'b0; bus4.idex_memread = 1'b0;
    bus4.idex_rt = 5'd0; bus4.ifid_rs = 5'd0; bus4.ifid_rt = 5'd0; bus4.ifid_uses_rt = 1'b0;
    bus4.redirect = 1'b0; bus4.halt_wb = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_ctl", ctl, CTL_HOLD);
      check("rst_halted", bus.halted, 0);
      check("rst_cnt", bus.stall_cycles, 0);
      next_cycle();
    end
    nRST = 1'b1;
    @(negedge CLK);
    check("rel_ctl", ctl, CTL_ADVANCE);
    check("rel_cnt", bus.stall_cycles, 0);

    // Load-use on rs
    next_cycle();
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
    @(negedge CLK);
    check("lu_rs_ctl", ctl, CTL_LOADUSE);
    next_cycle();
    bus.idex_memread = 1'b0;
    @(negedge CLK);
    check("lu_after_ctl", ctl, CTL_ADVANCE);
    check("lu_cnt", bus.stall_cycles, 1);

    // Load into r0 never stalls
    next_cycle();
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    @(negedge CLK);
    check("lu_r0_ctl", ctl, CTL_ADVANCE);

    // rt match only counts when the instruction reads rt
    next_cycle();
    bus.idex_rt = 5'd7; bus.ifid_rs = 5'd2; bus.ifid_rt = 5'd7; bus.ifid_uses_rt = 1'b0;
    @(negedge CLK);
    check("lu_rt_unused_ctl", ctl, CTL_ADVANCE);
    check("lu_r0_cnt", bus.stall_cycles, 1);
    next_cycle();
    bus.ifid_uses_rt = 1'b1;
    @(negedge CLK);
    check("lu_rt_ctl", ctl, CTL_LOADUSE);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("lu_rt_cnt", bus.stall_cycles, 2);

    // Data miss for four cycles, release on dhit
    next_cycle();
    bus.mem_op = 1'b1; bus.dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("dmiss_ctl", ctl, CTL_HOLD);
      next_cycle();
    end
    bus.dhit = 1'b1;
    @(negedge CLK);
    check("dmiss_rel_ctl", ctl, CTL_ADVANCE);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("dmiss_cnt", bus.stall_cycles, 6);

    // One-cycle miss whose release coincides with a fetch miss
    next_cycle();
    bus.mem_op = 1'b1; bus.dhit = 1'b0;
    @(negedge CLK);
    check("dmiss2_ctl", ctl, CTL_HOLD);
    next_cycle();
    bus.dhit = 1'b1; bus.ihit = 1'b0;
    @(negedge CLK);
    check("dmiss2_imiss_ctl", ctl, CTL_IMISS);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("dmiss2_cnt", bus.stall_cycles, 8);

    // Redirect beats load-use and fetch miss
    next_cycle();
    bus.redirect = 1'b1; bus.ihit = 1'b0;
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd3; bus.ifid_rs = 5'd3;
    @(negedge CLK);
    check("redir_ctl", ctl, CTL_REDIRECT);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("redir_cnt", bus.stall_cycles, 8);

    // Halt drain
    next_cycle();
    bus.halt_wb = 1'b1;
    @(negedge CLK);
    check("halt_ctl", ctl, CTL_HOLD);
    check("halt_first_halted", bus.halted, 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      bus.halt_wb = 1'b0;
      bus.ihit = i[0]; bus.dhit = i[1]; bus.mem_op = i[0];
      bus.redirect = ~i[0]; bus.idex_memread = 1'b1;
      bus.idex_rt = 5'd4; bus.ifid_rs = 5'd4;
      @(negedge CLK);
      check("halted_ctl", ctl, CTL_HOLD);
      check("halted_flag", bus.halted, 1);
      check("halted_cnt", bus.stall_cycles, 9);
    end
    next_cycle();
    nRST = 1'b0;
    @(negedge CLK);
    check("halt_rst_flag", bus.halted, 0);
    check("halt_rst_ctl", ctl, CTL_HOLD);
    next_cycle();
    nRST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    check("halt_rst_cnt", bus.stall_cycles, 0);
    check("halt_rst_run_ctl", ctl, CTL_ADVANCE);

    // Saturation on the 4-bit instance with fetch permanently missing
    next_cycle();
    nRST4 = 1'b1;
    @(negedge CLK);
    check("sat_start_cnt", bus4.stall_cycles, 0);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      @(negedge CLK);
      check("sat_cnt", bus4.stall_cycles, (k > 15) ? 15 : k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
